// File: rtl/gb_mul_pkg.sv
// Shared types and sizing helpers for the gb multiplier carry-propagate stage.
package gb_mul_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Slices needed to reach the requested product half: the high half needs
  // the carry chain to run through the whole 2*width vector.
  function automatic int n_slices(input int width, input int slice, input logic hi);
    return hi ? ceil_div(2 * width, slice) : ceil_div(width, slice);
  endfunction

endpackage

// File: rtl/gb_mul_cpa_if.sv
// Handshake and data bundle between the compressor tree and the CPA stage.
interface gb_mul_cpa_if #(
  parameter int WIDTH = gb_mul_pkg::DEF_WIDTH
);
  import gb_mul_pkg::*;

  logic               i_valid;
  logic               o_ready;
  logic [2*WIDTH-1:0] i_sum;
  logic [2*WIDTH-1:0] i_carry;
  logic               i_hi;
  logic               i_flush;
  logic               o_valid;
  logic               i_ready;
  logic [WIDTH-1:0]   o_result;
  logic               o_busy;

  modport master (
    output i_valid, i_sum, i_carry, i_hi, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_busy
  );

  modport slave (
    input  i_valid, i_sum, i_carry, i_hi, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_busy
  );

endinterface

// File: rtl/gb_mul_cpa_slice.sv
// Combinational SLICE-bit adder; reused every cycle by the CPA sequencer.
module gb_mul_cpa_slice
  import gb_mul_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/gb_mul_cpa.sv
// Multi-cycle carry-propagate adder: resolves sum/carry into a binary product,
// one SLICE-bit chunk per cycle, returning the low or high product half.
module gb_mul_cpa
  import gb_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  gb_mul_cpa_if.slave   bus
);

  localparam int NLO   = n_slices(WIDTH, SLICE, 1'b0);
  localparam int NHI   = n_slices(WIDTH, SLICE, 1'b1);
  localparam int CNT_W = $clog2(NHI + 1);

  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("gb_mul_cpa: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   sum_p0, carry_p0;
  logic                 hi_p0;
  logic [2*WIDTH-1:0]   acc_p1, acc_nxt;
  logic [CNT_W-1:0]     k_p1;
  logic                 cy_p1;
  logic [WIDTH-1:0]     result_q;
  logic [SLICE-1:0]     sl_a, sl_b, sl_s;
  logic                 sl_cout;
  logic                 last_slice;
  logic                 accept;
  int                   base;

  assign accept     = (state == S_IDLE) && bus.i_valid && !bus.i_flush;
  assign last_slice = (k_p1 == (hi_p0 ? CNT_W'(NHI - 1) : CNT_W'(NLO - 1)));

  // Select the operand chunk addressed by the slice counter.
  always_comb begin
    base = 32'(k_p1) * SLICE;
    sl_a = sum_p0[base +: SLICE];
    sl_b = carry_p0[base +: SLICE];
  end

  gb_mul_cpa_slice #(.SLICE(SLICE)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (cy_p1),
    .s    (sl_s),
    .cout (sl_cout)
  );

  // Accumulator with the current slice merged in; feeds both the register and the result.
  always_comb begin
    acc_nxt = acc_p1;
    acc_nxt[base +: SLICE] = sl_s;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; flush overrides both accept and the DONE handshake.
  always_comb begin
    state_nxt = state;
    if (bus.i_flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.i_valid) state_nxt = S_ADD;
        S_ADD:   if (last_slice)  state_nxt = S_DONE;
        S_DONE:  if (bus.i_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Operand capture, slice sequencing and result update (result only changes on entry to DONE).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_p0   <= '0;
      carry_p0 <= '0;
      hi_p0    <= 1'b0;
      acc_p1   <= '0;
      k_p1     <= '0;
      cy_p1    <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      sum_p0   <= bus.i_sum;
      carry_p0 <= bus.i_carry;
      hi_p0    <= bus.i_hi;
      acc_p1   <= '0;
      k_p1     <= '0;
      cy_p1    <= 1'b0;
    end else if (bus.i_flush) begin
      k_p1     <= '0;
      cy_p1    <= 1'b0;
    end else if (state == S_ADD) begin
      acc_p1   <= acc_nxt;
      cy_p1    <= sl_cout;
      k_p1     <= k_p1 + 1'b1;
      if (last_slice)
        result_q <= hi_p0 ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
    end
  end

  assign bus.o_ready  = (state == S_IDLE);
  assign bus.o_valid  = (state == S_DONE);
  assign bus.o_busy   = (state != S_IDLE);
  assign bus.o_result = result_q;

endmodule
